// File: rtl/busy_monitor_mc.sv
// Per-channel busy tracker: start raises busy; busy drops HOLD_CYC cycles after the last stop/activity, or on watchdog expiry.
// Latency: busy, busy_any, done and tmo_flag all update on the edge that samples the causing pulse. There is no backpressure.
module busy_monitor_mc #(
    parameter int NCH      = 4,
    parameter int HOLD_W   = 8,
    parameter int HOLD_CYC = 255,
    parameter int TMO_W    = 16,
    parameter int TMO_CYC  = 65535
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] enable,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    input  logic [NCH-1:0] activity,
    input  logic [NCH-1:0] clear_tmo,
    output logic [NCH-1:0] busy,
    output logic           busy_any,
    output logic [NCH-1:0] done,
    output logic [NCH-1:0] tmo_flag
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);
    localparam bit                TMO_ON    = (TMO_CYC != 0);

    logic [NCH-1:0] busy_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t            state;
        logic [HOLD_W-1:0] hold_cnt;
        logic [TMO_W-1:0]  tmo_cnt;
        logic [TMO_W-1:0]  tmo_inc;
        logic              done_q;
        logic              flag_q;
        logic              retrig;
        logic              wd_fire;
        logic              hold_exp;

        assign retrig   = stop[g] | activity[g];
        assign tmo_inc  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        assign wd_fire  = TMO_ON && (state != IDLE) && (tmo_cnt == TMO_LAST);
        // A retrigger or a restart on the expiry edge keeps the channel alive.
        assign hold_exp = (state == HOLD) && !start[g] && !retrig && (hold_cnt == HOLD_LAST);

        // busy_any is registered from the next-state view so it rises and falls with busy.
        assign busy_nxt[g] = enable[g] && !wd_fire && !hold_exp && ((state != IDLE) || start[g]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state    <= IDLE;
                hold_cnt <= '0;
                tmo_cnt  <= '0;
                done_q   <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (wd_fire && enable[g]) begin
                    flag_q <= 1'b1;
                end else if (clear_tmo[g]) begin
                    flag_q <= 1'b0;
                end

                if (!enable[g] || wd_fire) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    tmo_cnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (start[g]) begin
                                state   <= ACTIVE;
                                tmo_cnt <= '0;
                            end
                        end
                        ACTIVE: begin
                            tmo_cnt <= start[g] ? '0 : tmo_inc;
                            if (retrig) begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_W'(1);
                            end
                        end
                        HOLD: begin
                            tmo_cnt <= start[g] ? '0 : tmo_inc;
                            if (start[g]) begin
                                state    <= ACTIVE;
                                hold_cnt <= '0;
                            end else if (retrig) begin
                                hold_cnt <= HOLD_W'(1);
                            end else if (hold_exp) begin
                                state    <= IDLE;
                                hold_cnt <= '0;
                                tmo_cnt  <= '0;
                                done_q   <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign busy[g]     = (state != IDLE);
        assign done[g]     = done_q;
        assign tmo_flag[g] = flag_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_any <= 1'b0;
        end else begin
            busy_any <= |busy_nxt;
        end
    end

endmodule
